// File: rtl/hovalaag_frame_io.sv
// Slot-framed pin I/O for the Hovalaag core: assembles 5x6-bit input samples into
// 30-bit frames (2-deep FIFO) and serializes 24-bit results plus status/sync bytes.
module hovalaag_frame_io (
    input  logic        clk,
    input  logic        reset,
    input  logic        slot_clear,
    input  logic        ovf_clear,
    input  logic [5:0]  data_in,
    output logic [2:0]  slot,
    output logic [29:0] frame_word,
    output logic        frame_valid,
    input  logic        frame_ready,
    input  logic [23:0] result_in,
    input  logic        result_valid,
    output logic        result_ready,
    output logic [7:0]  data_out,
    output logic        overflow
);

    localparam int unsigned FRAME_W = 30;
    localparam int unsigned RES_W   = 24;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = 2;

    localparam logic [2:0]        LAST_SLOT = 3'd4;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

    logic [RES_W-1:0]   acc, acc_nxt;
    logic [FRAME_W-1:0] mem [DEPTH];
    logic [FRAME_W-1:0] push_word;
    logic               rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, count_nxt;

    logic [RES_W-1:0]   hold, hold_nxt;
    logic [RES_W-1:0]   shadow, shadow_nxt;
    logic               hold_valid, hold_valid_nxt;
    logic               fresh, fresh_nxt;

    logic [2:0]         slot_nxt;
    logic               ovf_nxt;
    logic [BYTE_W-1:0]  data_out_nxt;
    logic               push_req, push, pop, drop, load, boundary;

    // Next-state for slot counter, frame assembly, FIFO, result path and pin byte
    always_comb begin
        slot_nxt       = slot + 3'd1;
        acc_nxt        = acc;
        push_word      = {data_in, acc};
        hold_nxt       = hold;
        hold_valid_nxt = hold_valid;
        shadow_nxt     = shadow;
        fresh_nxt      = fresh;
        data_out_nxt   = SYNC_BYTE;

        if (slot_clear || slot == LAST_SLOT) begin
            slot_nxt = 3'd0;
        end
        boundary = slot_clear || (slot == LAST_SLOT);

        if (!slot_clear) begin
            case (slot)
                3'd0:    acc_nxt[5:0]   = data_in;
                3'd1:    acc_nxt[11:6]  = data_in;
                3'd2:    acc_nxt[17:12] = data_in;
                3'd3:    acc_nxt[23:18] = data_in;
                default: acc_nxt        = acc;
            endcase
        end

        push_req  = (slot == LAST_SLOT) && !slot_clear;
        pop       = frame_valid && frame_ready;
        push      = push_req && ((count != FULL_CNT) || pop);
        drop      = push_req && (count == FULL_CNT) && !pop;
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        ovf_nxt   = drop ? 1'b1 : (ovf_clear ? 1'b0 : overflow);

        // Holding register can only load while empty, so it never races the transfer
        load = result_valid && result_ready;
        if (boundary) begin
            if (hold_valid) begin
                shadow_nxt     = hold;
                hold_valid_nxt = 1'b0;
                fresh_nxt      = 1'b1;
            end else begin
                fresh_nxt = 1'b0;
            end
        end
        if (load) begin
            hold_nxt       = result_in;
            hold_valid_nxt = 1'b1;
        end

        case (slot_nxt)
            3'd0:    data_out_nxt = shadow_nxt[7:0];
            3'd1:    data_out_nxt = shadow_nxt[15:8];
            3'd2:    data_out_nxt = shadow_nxt[23:16];
            3'd3:    data_out_nxt = {ovf_nxt, count_nxt, fresh_nxt, 4'h0};
            default: data_out_nxt = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot         <= 3'd0;
            acc          <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= '0;
            frame_valid  <= 1'b0;
            overflow     <= 1'b0;
            hold         <= '0;
            hold_valid   <= 1'b0;
            result_ready <= 1'b1;
            shadow       <= '0;
            fresh        <= 1'b0;
            data_out     <= '0;
        end else begin
            slot         <= slot_nxt;
            acc          <= acc_nxt;
            if (push) begin
                mem[wr_ptr] <= push_word;
            end
            wr_ptr       <= wr_ptr ^ push;
            rd_ptr       <= rd_ptr ^ pop;
            count        <= count_nxt;
            frame_valid  <= (count_nxt != '0);
            overflow     <= ovf_nxt;
            hold         <= hold_nxt;
            hold_valid   <= hold_valid_nxt;
            result_ready <= !hold_valid_nxt;
            shadow       <= shadow_nxt;
            fresh        <= fresh_nxt;
            data_out     <= data_out_nxt;
        end
    end

    assign frame_word = mem[rd_ptr];

endmodule

// File: tb/tb_hovalaag_frame_io.sv
// Bench for hovalaag_frame_io: directed vector table, hand-written corner sequences,
// and randomized traffic, all checked against a frame/queue-level reference model.
module tb_hovalaag_frame_io;

    logic        clk = 1'b0;
    logic        reset;
    logic        slot_clear, ovf_clear, frame_ready, result_valid;
    logic [5:0]  data_in;
    logic [23:0] result_in;
    logic [2:0]  slot;
    logic [29:0] frame_word;
    logic        frame_valid, result_ready, overflow;
    logic [7:0]  data_out;

    int checks = 0;
    int errors = 0;

    hovalaag_frame_io dut (
        .clk          (clk),
        .reset        (reset),
        .slot_clear   (slot_clear),
        .ovf_clear    (ovf_clear),
        .data_in      (data_in),
        .slot         (slot),
        .frame_word   (frame_word),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .result_in    (result_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .data_out     (data_out),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: sample array, frame queue, result hold/shadow bookkeeping
    int          m_slot;
    logic [5:0]  m_smp [5];
    logic [29:0] m_q [$];
    bit          m_ovf, m_hv, m_fresh;
    logic [23:0] m_hold, m_shadow;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_slot = 0;
        for (int k = 0; k < 5; k++) m_smp[k] = '0;
        m_q.delete();
        m_ovf = 0; m_hv = 0; m_fresh = 0;
        m_hold = '0; m_shadow = '0;
    endtask

    function automatic logic [7:0] m_dout();
        case (m_slot)
            0:       return m_shadow[7:0];
            1:       return m_shadow[15:8];
            2:       return m_shadow[23:16];
            3:       return {m_ovf, 2'(m_q.size()), m_fresh, 4'h0};
            default: return 8'hA5;
        endcase
    endfunction

    task automatic model_edge();
        bit boundary, pop, push_req, ld, drop;
        logic [29:0] w;
        boundary = slot_clear || (m_slot == 4);
        pop      = (m_q.size() != 0) && frame_ready;
        push_req = (m_slot == 4) && !slot_clear;
        ld       = result_valid && !m_hv;
        drop     = 0;
        if (!slot_clear) m_smp[m_slot] = data_in;
        for (int k = 0; k < 5; k++) w[6*k +: 6] = m_smp[k];
        if (pop) void'(m_q.pop_front());
        if (push_req) begin
            if (m_q.size() < 2) m_q.push_back(w);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (ovf_clear) m_ovf = 0;
        if (boundary) begin
            if (m_hv) begin
                m_shadow = m_hold;
                m_hv     = 0;
                m_fresh  = 1;
            end else begin
                m_fresh = 0;
            end
        end
        if (ld) begin
            m_hold = result_in;
            m_hv   = 1;
        end
        m_slot = (slot_clear || m_slot == 4) ? 0 : m_slot + 1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("slot", 32'(slot), 32'(m_slot));
        check("frame_valid", 32'(frame_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("frame_word", 32'(frame_word), 32'(m_q[0]));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("result_ready", 32'(result_ready), 32'(!m_hv));
        check("data_out", 32'(data_out), 32'(m_dout()));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_slot"},         32'(slot),         32'd0);
        check({tag, "_frame_valid"},  32'(frame_valid),  32'd0);
        check({tag, "_frame_word"},   32'(frame_word),   32'd0);
        check({tag, "_overflow"},     32'(overflow),     32'd0);
        check({tag, "_result_ready"}, 32'(result_ready), 32'd1);
        check({tag, "_data_out"},     32'(data_out),     32'd0);
    endtask

    task automatic idle_inputs();
        slot_clear = 0; ovf_clear = 0; frame_ready = 0;
        result_valid = 0; result_in = '0; data_in = '0;
    endtask

    // Called just after a sampling point; pulses reset between clock edges
    task automatic do_reset();
        #3 reset = 1'b1;
        #1 model_reset();
        check_reset_vals("rst");
        #2 reset = 1'b0;
        idle_inputs();
    endtask

    function automatic logic [29:0] fw(input logic [5:0] base);
        logic [29:0] w;
        for (int k = 0; k < 5; k++) w[6*k +: 6] = base + 6'(k);
        return w;
    endfunction

    task automatic send_frame(input logic [5:0] base);
        for (int k = 0; k < 5; k++) begin
            data_in = base + 6'(k);
            tick();
        end
        data_in = '0;
    endtask

    typedef struct {
        logic [5:0]  din;
        logic        sc;
        logic        fr;
        logic [2:0]  exp_slot;
        logic        exp_valid;
        logic [29:0] exp_word;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [29:0] w1;
        w1 = 30'((5 << 24) | (4 << 18) | (3 << 12) | (2 << 6) | 1);
        vecs[0]  = '{6'd1,  1'b0, 1'b0, 3'd1, 1'b0, 30'h0};
        vecs[1]  = '{6'd2,  1'b0, 1'b0, 3'd2, 1'b0, 30'h0};
        vecs[2]  = '{6'd3,  1'b0, 1'b0, 3'd3, 1'b0, 30'h0};
        vecs[3]  = '{6'd4,  1'b0, 1'b0, 3'd4, 1'b0, 30'h0};
        vecs[4]  = '{6'd5,  1'b0, 1'b0, 3'd0, 1'b1, w1};
        vecs[5]  = '{6'd7,  1'b0, 1'b1, 3'd1, 1'b0, 30'h0};
        vecs[6]  = '{6'd8,  1'b0, 1'b1, 3'd2, 1'b0, 30'h0};
        vecs[7]  = '{6'd9,  1'b1, 1'b1, 3'd0, 1'b0, 30'h0};
        vecs[8]  = '{6'h3F, 1'b0, 1'b0, 3'd1, 1'b0, 30'h0};
        vecs[9]  = '{6'h3F, 1'b0, 1'b0, 3'd2, 1'b0, 30'h0};
        vecs[10] = '{6'h3F, 1'b0, 1'b0, 3'd3, 1'b0, 30'h0};
        vecs[11] = '{6'h3F, 1'b0, 1'b0, 3'd4, 1'b0, 30'h0};
        vecs[12] = '{6'h3F, 1'b0, 1'b0, 3'd0, 1'b1, 30'h3FFFFFFF};
        vecs[13] = '{6'd0,  1'b0, 1'b1, 3'd1, 1'b0, 30'h0};

        reset = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        check_reset_vals("init");
        #10 reset = 1'b0;

        // Frame assembly and slot_clear resync
        for (int i = 0; i < 14; i++) begin
            data_in     = vecs[i].din;
            slot_clear  = vecs[i].sc;
            frame_ready = vecs[i].fr;
            tick();
            check($sformatf("vec%0d_slot", i), 32'(slot), 32'(vecs[i].exp_slot));
            check($sformatf("vec%0d_valid", i), 32'(frame_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("vec%0d_word", i), 32'(frame_word), 32'(vecs[i].exp_word));
        end
        idle_inputs();

        // Overflow: third frame dropped while consumer stalls
        do_reset();
        send_frame(6'h08);
        send_frame(6'h10);
        send_frame(6'h18);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", 32'(frame_word), 32'(fw(6'h08)));
        repeat (3) tick();
        check("ovf_status", 32'(data_out), 32'h0000_00C0);
        frame_ready = 1; tick(); frame_ready = 0;
        check("ovf_second", 32'(frame_word), 32'(fw(6'h10)));
        ovf_clear = 1; tick(); ovf_clear = 0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("ovf_head_kept", 32'(frame_word), 32'(fw(6'h10)));

        // Push into a full FIFO coinciding with a pop
        do_reset();
        send_frame(6'h01);
        send_frame(6'h0A);
        for (int k = 0; k < 4; k++) begin
            data_in = 6'h14 + 6'(k);
            tick();
        end
        data_in = 6'h18; frame_ready = 1; tick(); frame_ready = 0; data_in = '0;
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_head", 32'(frame_word), 32'(fw(6'h0A)));
        repeat (3) tick();
        check("pp_status", 32'(data_out), 32'h0000_0040);
        frame_ready = 1; tick(); frame_ready = 0;
        check("pp_third", 32'(frame_word), 32'(fw(6'h14)));

        // Result serialization with fresh flag
        do_reset();
        frame_ready = 1;
        repeat (2) tick();
        result_in = 24'hC0FFEE; result_valid = 1; tick(); result_valid = 0;
        check("res_ready_low", 32'(result_ready), 32'd0);
        repeat (2) tick();
        check("res_ready_high", 32'(result_ready), 32'd1);
        check("res_b0", 32'(data_out), 32'h0000_00EE);
        tick(); check("res_b1", 32'(data_out), 32'h0000_00FF);
        tick(); check("res_b2", 32'(data_out), 32'h0000_00C0);
        tick(); check("res_stat_fresh", 32'(data_out), 32'h0000_0010);
        tick(); check("res_sync", 32'(data_out), 32'h0000_00A5);
        tick(); check("res2_b0", 32'(data_out), 32'h0000_00EE);
        tick(); check("res2_b1", 32'(data_out), 32'h0000_00FF);
        tick(); check("res2_b2", 32'(data_out), 32'h0000_00C0);
        tick(); check("res2_stat", 32'(data_out), 32'h0000_0000);
        tick(); check("res2_sync", 32'(data_out), 32'h0000_00A5);
        frame_ready = 0;

        // Reset in slot 3 with FIFO and holding register full
        do_reset();
        send_frame(6'h11);
        send_frame(6'h22);
        result_in = 24'h123456; result_valid = 1; tick(); result_valid = 0;
        repeat (2) tick();
        check("mid_slot", 32'(slot), 32'd3);
        check("mid_full", 32'(frame_valid), 32'd1);
        check("mid_hold", 32'(result_ready), 32'd0);
        do_reset();
        frame_ready = 0;
        send_frame(6'h05);
        check("post_word", 32'(frame_word), 32'(fw(6'h05)));
        check("post_ovf", 32'(overflow), 32'd0);
        check("post_dout", 32'(data_out), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            data_in      = 6'($urandom);
            slot_clear   = ($urandom_range(0, 19) == 0);
            ovf_clear    = ($urandom_range(0, 15) == 0);
            frame_ready  = ($urandom_range(0, 2) == 0);
            result_valid = ($urandom_range(0, 3) == 0);
            result_in    = 24'($urandom);
            tick();
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
